// File: rtl/prog_run_pkg.sv
// Shared definitions for the program-run sequencer: FSM state encoding and
// default widths used by the interface and the top level.
package prog_run_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int CYC_W_DEF  = 16;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_WAIT_LOW = 3'd2,
        S_RUN      = 3'd3,
        S_REPORT   = 3'd4
    } state_t;

endpackage

// File: rtl/prog_run_sequencer_if.sv
// Host/core-facing signal bundle of the program-run sequencer.
// The slave modport is the sequencer's view; the master modport is the view
// of whatever drives it (host pushes, core done, result consumer).
interface prog_run_sequencer_if
    import prog_run_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CYC_W  = CYC_W_DEF
);
    logic              push_i;
    logic [ADDR_W-1:0] push_addr_i;
    logic              full_o;
    logic              empty_o;
    logic              start_o;
    logic [ADDR_W-1:0] start_addr_o;
    logic              done_i;
    logic              busy_o;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [ADDR_W-1:0] res_addr_o;
    logic [CYC_W-1:0]  res_cycles_o;
    logic              res_timeout_o;

    modport slave (
        input  push_i, push_addr_i, done_i, res_ready_i,
        output full_o, empty_o, start_o, start_addr_o, busy_o,
               res_valid_o, res_addr_o, res_cycles_o, res_timeout_o
    );

    modport master (
        output push_i, push_addr_i, done_i, res_ready_i,
        input  full_o, empty_o, start_o, start_addr_o, busy_o,
               res_valid_o, res_addr_o, res_cycles_o, res_timeout_o
    );

endinterface

// File: rtl/prog_run_fifo.sv
// Small synchronous FIFO holding queued program start addresses.
// Push while full is dropped unless a pop happens in the same cycle.
// Storage is not reset; only pointers and occupancy are.
module prog_run_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Write accepted entries into storage.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Advance pointers (DEPTH is a power of two, so they wrap naturally) and track occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prog_run_sequencer.sv
// Program-run sequencer: pops queued start addresses, pulses the core's start,
// waits for the core's done handshake and reports address and run length.
// Optional watchdog: define PROG_RUN_SEQ_TIMEOUT_EN to enable the TIMEOUT
// parameter and the res_timeout_o flag; otherwise res_timeout_o is tied 0.
module prog_run_sequencer
    import prog_run_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CYC_W  = CYC_W_DEF
`ifdef PROG_RUN_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 4096
`endif
) (
    input logic                  clock_i,
    input logic                  reset_i,
    prog_run_sequencer_if.slave  bus
);
`ifdef PROG_RUN_SEQ_TIMEOUT_EN
    localparam logic [CYC_W-1:0] TMO_CNT = CYC_W'(TIMEOUT);
`endif

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [CYC_W-1:0]  cnt;
    logic              start_q;
    logic              busy_q;
    logic              res_valid_q;
    logic [ADDR_W-1:0] res_addr_q;
    logic [CYC_W-1:0]  res_cycles_q;
`ifdef PROG_RUN_SEQ_TIMEOUT_EN
    logic              res_timeout_q;
`endif

    logic              pop;
    logic [ADDR_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;

    // Run-length counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign pop = (state == S_IDLE) && !fifo_empty;

    prog_run_fifo #(
        .W     (ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clock_i),
        .rst   (reset_i),
        .push  (bus.push_i),
        .din   (bus.push_addr_i),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.full_o       = fifo_full;
    assign bus.empty_o      = fifo_empty;
    assign bus.start_o      = start_q;
    assign bus.start_addr_o = addr_q;
    assign bus.busy_o       = busy_q;
    assign bus.res_valid_o  = res_valid_q;
    assign bus.res_addr_o   = res_addr_q;
    assign bus.res_cycles_o = res_cycles_q;
`ifdef PROG_RUN_SEQ_TIMEOUT_EN
    assign bus.res_timeout_o = res_timeout_q;
`else
    assign bus.res_timeout_o = 1'b0;
`endif

    // Run sequencing FSM with cycle counter; every output is registered on its transition.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            cnt           <= '0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_addr_q    <= '0;
            res_cycles_q  <= '0;
`ifdef PROG_RUN_SEQ_TIMEOUT_EN
            res_timeout_q <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        addr_q  <= head;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // The launch cycle itself counts as cycle 1 of the run.
                    cnt   <= CYC_W'(1);
                    state <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
`ifdef PROG_RUN_SEQ_TIMEOUT_EN
                    if (cnt == TMO_CNT) begin
                        res_addr_q    <= addr_q;
                        res_cycles_q  <= TMO_CNT;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        busy_q        <= 1'b0;
                        state         <= S_REPORT;
                    end else
`endif
                    begin
                        // Keep counting across the transition so cnt always equals cycles since launch.
                        cnt <= sat_inc(cnt);
                        if (!bus.done_i) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
`ifdef PROG_RUN_SEQ_TIMEOUT_EN
                    if (cnt == TMO_CNT) begin
                        res_addr_q    <= addr_q;
                        res_cycles_q  <= TMO_CNT;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        busy_q        <= 1'b0;
                        state         <= S_REPORT;
                    end else
`endif
                    if (bus.done_i) begin
                        res_addr_q   <= addr_q;
                        res_cycles_q <= cnt;
`ifdef PROG_RUN_SEQ_TIMEOUT_EN
                        res_timeout_q <= 1'b0;
`endif
                        res_valid_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state        <= S_REPORT;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                S_REPORT: begin
                    if (bus.res_ready_i) begin
                        res_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
